// File: rtl/gm64_pkg.sv
// Shared types and constants for the PSRAM arbiter slice.
package gm64_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 8;

  // Data returned to a requester whose transaction was abandoned on timeout.
  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 8'hFF;

  typedef enum logic [2:0] {
    arbIdle,
    arbIssue,
    arbWaitBusy,
    arbDone,
    arbResp
  } ArbState;

  typedef enum logic {
    ownVic,
    ownCpu
  } Owner;

endpackage

// File: rtl/psram_arbiter_if.sv
// Requester and memCtrl signals of the PSRAM arbiter, bundled as one interface.
// slave  : the arbiter's own view (samples requests / memCtrl status, drives acks and strobes).
// master : the surrounding system's view (requesters plus memCtrl).
interface psram_arbiter_if;
  import gm64_pkg::*;

  // VIC read-only requester
  logic              i_vicReq;
  logic [ADDR_W-1:0] i_vicAddr;
  logic              o_vicAck;
  logic [DATA_W-1:0] o_vicData;

  // CPU read/write requester
  logic              i_cpuReq;
  logic              i_cpuWe;
  logic [ADDR_W-1:0] i_cpuAddr;
  logic [DATA_W-1:0] i_cpuDataW;
  logic              o_cpuAck;
  logic [DATA_W-1:0] o_cpuData;

  // memCtrl port
  logic              o_cs;
  logic              o_write;
  logic [ADDR_W-1:0] o_address;
  logic [DATA_W-1:0] o_dataToWrite;
  logic [DATA_W-1:0] i_dataRead;
  logic              i_busy;
  logic              i_dataReady;

  // status
  logic              o_error;

  modport slave (
    input  i_vicReq, i_vicAddr,
    output o_vicAck, o_vicData,
    input  i_cpuReq, i_cpuWe, i_cpuAddr, i_cpuDataW,
    output o_cpuAck, o_cpuData,
    output o_cs, o_write, o_address, o_dataToWrite,
    input  i_dataRead, i_busy, i_dataReady,
    output o_error
  );

  modport master (
    output i_vicReq, i_vicAddr,
    input  o_vicAck, o_vicData,
    output i_cpuReq, i_cpuWe, i_cpuAddr, i_cpuDataW,
    input  o_cpuAck, o_cpuData,
    input  o_cs, o_write, o_address, o_dataToWrite,
    output i_dataRead, i_busy, i_dataReady,
    input  o_error
  );

endinterface

// File: rtl/psram_arbiter_priority.sv
// Grant decision between VIC and CPU, with the VIC streak limiter.
// VIC normally wins; once VIC_BURST VIC grants have been given while the CPU
// was waiting, the CPU takes the next slot.
module arb_priority
  import gm64_pkg::*;
#(
  parameter int VIC_BURST = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en,
  input  logic vic_req,
  input  logic cpu_req,
  output logic grant,
  output Owner grant_owner
);

  localparam int SW = (VIC_BURST < 1) ? 1 : $clog2(VIC_BURST + 1);
  localparam logic [SW-1:0] BURST_MAX = SW'(VIC_BURST);

  logic [SW-1:0] streak_reg;
  logic [SW-1:0] streak_next;
  logic          cpu_turn;

  // Grant decision and next streak value.
  always_comb begin
    streak_next = streak_reg;
    cpu_turn    = cpu_req && (streak_reg == BURST_MAX);
    grant       = arb_en && (vic_req || cpu_req);
    grant_owner = (cpu_req && (!vic_req || cpu_turn)) ? ownCpu : ownVic;

    if (!cpu_req) begin
      streak_next = '0;
    end else if (grant) begin
      if (grant_owner == ownCpu) begin
        streak_next = '0;
      end else if (streak_reg != BURST_MAX) begin
        streak_next = streak_reg + 1'b1;
      end
    end
  end

  // Streak register.
  always_ff @(posedge clk) begin
    if (reset) begin
      streak_reg <= '0;
    end else begin
      streak_reg <= streak_next;
    end
  end

endmodule

// File: rtl/psram_arbiter.sv
// PSRAM arbiter: shares the single memCtrl port between the VIC (reads) and
// the CPU (reads/writes). One memCtrl transaction at a time:
// IDLE -> ISSUE (cs pulse) -> WAITB (busy rises) -> DONE (busy falls / data
// ready) -> RESP (one-cycle ack to the owner). A stalled memCtrl is abandoned
// after TIMEOUT cycles in WAITB or DONE with data 8'hFF and a sticky error.
module psram_arbiter
  import gm64_pkg::*;
#(
  parameter int VIC_BURST = 4,
  parameter int TIMEOUT   = 1023
) (
  input logic            clkSys,
  input logic            reset,
  psram_arbiter_if.slave bus
);

  // Counter only needs to reach TIMEOUT-1; the wait ends on that cycle.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);

  ArbState           state_reg, state_next;
  Owner              owner_reg, owner_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic              cs_reg, cs_next;
  logic              write_reg, write_next;
  logic [ADDR_W-1:0] address_reg, address_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              vic_ack_reg, vic_ack_next;
  logic              cpu_ack_reg, cpu_ack_next;
  logic [DATA_W-1:0] vic_data_reg, vic_data_next;
  logic [DATA_W-1:0] cpu_data_reg, cpu_data_next;
  logic              error_reg, error_next;

  logic              arb_en;
  logic              grant;
  Owner              grant_owner;
  logic              finish;
  logic              timed_out;
  logic [DATA_W-1:0] resp_data;

  // Arbitration only happens while idle and memCtrl is free.
  assign arb_en = (state_reg == arbIdle) && !bus.i_busy;

  arb_priority #(
    .VIC_BURST (VIC_BURST)
  ) u_priority (
    .clk         (clkSys),
    .reset       (reset),
    .arb_en      (arb_en),
    .vic_req     (bus.i_vicReq),
    .cpu_req     (bus.i_cpuReq),
    .grant       (grant),
    .grant_owner (grant_owner)
  );

  // Next-state and registered-output logic of the transaction sequencer.
  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    cnt_next      = cnt_reg;
    cs_next       = 1'b1;
    write_next    = write_reg;
    address_next  = address_reg;
    wdata_next    = wdata_reg;
    vic_ack_next  = 1'b0;
    cpu_ack_next  = 1'b0;
    vic_data_next = vic_data_reg;
    cpu_data_next = cpu_data_reg;
    error_next    = error_reg;
    finish        = 1'b0;
    timed_out     = 1'b0;

    unique case (state_reg)
      arbIdle: begin
        if (grant) begin
          state_next = arbIssue;
          owner_next = grant_owner;
          cnt_next   = '0;
          cs_next    = 1'b0;
          if (grant_owner == ownCpu) begin
            address_next = bus.i_cpuAddr;
            write_next   = bus.i_cpuWe;
            wdata_next   = bus.i_cpuDataW;
          end else begin
            address_next = bus.i_vicAddr;
            write_next   = 1'b0;
            wdata_next   = '0;
          end
        end
      end

      arbIssue: begin
        state_next = arbWaitBusy;
      end

      arbWaitBusy: begin
        if (bus.i_busy) begin
          state_next = arbDone;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          finish    = 1'b1;
          timed_out = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      arbDone: begin
        // Writes complete on busy falling; reads also need the data strobe.
        if (!bus.i_busy && (write_reg || bus.i_dataReady)) begin
          finish = 1'b1;
        end else if (cnt_reg == CNT_LAST) begin
          finish    = 1'b1;
          timed_out = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      arbResp: begin
        state_next = arbIdle;
      end

      default: begin
        state_next = arbIdle;
      end
    endcase

    resp_data = timed_out ? TIMEOUT_DATA : bus.i_dataRead;

    // Completion (normal or abandoned): load the owner's data and ack for RESP.
    if (finish) begin
      state_next = arbResp;
      if (timed_out) begin
        error_next = 1'b1;
      end
      if (owner_reg == ownVic) begin
        vic_ack_next  = 1'b1;
        vic_data_next = resp_data;
      end else begin
        cpu_ack_next = 1'b1;
        if (timed_out || !write_reg) begin
          cpu_data_next = resp_data;
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clkSys) begin
    if (reset) begin
      state_reg    <= arbIdle;
      owner_reg    <= ownVic;
      cnt_reg      <= '0;
      cs_reg       <= 1'b1;
      write_reg    <= 1'b0;
      address_reg  <= '0;
      wdata_reg    <= '0;
      vic_ack_reg  <= 1'b0;
      cpu_ack_reg  <= 1'b0;
      vic_data_reg <= '0;
      cpu_data_reg <= '0;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      cnt_reg      <= cnt_next;
      cs_reg       <= cs_next;
      write_reg    <= write_next;
      address_reg  <= address_next;
      wdata_reg    <= wdata_next;
      vic_ack_reg  <= vic_ack_next;
      cpu_ack_reg  <= cpu_ack_next;
      vic_data_reg <= vic_data_next;
      cpu_data_reg <= cpu_data_next;
      error_reg    <= error_next;
    end
  end

  assign bus.o_cs          = cs_reg;
  assign bus.o_write       = write_reg;
  assign bus.o_address     = address_reg;
  assign bus.o_dataToWrite = wdata_reg;
  assign bus.o_vicAck      = vic_ack_reg;
  assign bus.o_vicData     = vic_data_reg;
  assign bus.o_cpuAck      = cpu_ack_reg;
  assign bus.o_cpuData     = cpu_data_reg;
  assign bus.o_error       = error_reg;

endmodule

// File: tb/tb_psram_arbiter.sv
// Scoreboard bench for psram_arbiter with a small memCtrl model.
module tb_psram_arbiter;
  import gm64_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  psram_arbiter_if bus();

  psram_arbiter #(
    .VIC_BURST (4),
    .TIMEOUT   (1023)
  ) dut (
    .clkSys (clk),
    .reset  (reset),
    .bus    (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memCtrl model: busy for 6 cycles after a cs pulse ----------------
  localparam int BUSY_CYC = 6;
  bit          no_ready   = 1'b0;
  bit          force_busy = 1'b0;
  logic        m_busy, m_ready, m_we;
  logic [7:0]  m_rdata;
  logic [23:0] m_addr;
  int          m_cnt;
  logic [7:0]  mem [256];
  bit          written [256];

  always @(posedge clk) begin
    if (reset) begin
      m_busy  <= 1'b0;
      m_ready <= 1'b0;
      m_rdata <= 8'h00;
      m_cnt   <= 0;
      m_we    <= 1'b0;
      m_addr  <= 24'h0;
    end else if (!m_busy && !bus.o_cs) begin
      m_busy  <= 1'b1;
      m_cnt   <= BUSY_CYC;
      m_ready <= 1'b0;
      m_we    <= bus.o_write;
      m_addr  <= bus.o_address;
      if (bus.o_write) begin
        mem[bus.o_address[7:0]]     <= bus.o_dataToWrite;
        written[bus.o_address[7:0]] <= 1'b1;
      end
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        if (!m_we && !no_ready) begin
          m_ready <= 1'b1;
          m_rdata <= written[m_addr[7:0]] ? mem[m_addr[7:0]] : (m_addr[7:0] ^ 8'h5A);
        end
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  assign bus.i_busy      = m_busy | force_busy;
  assign bus.i_dataReady = m_ready;
  assign bus.i_dataRead  = m_rdata;

  // ---------------- scoreboard ----------------
  typedef struct {
    Owner       own;
    logic [7:0] data;
    bit         chk_data;
    bit         err;
    int         t0;
    int         lat;
    int         id;
  } exp_t;

  exp_t sb[$];
  int   next_id    = 0;
  int   n_expired  = 0;
  bit   chk_rst    = 1'b0;
  bit   final_chk  = 1'b0;

  task automatic expect_ack(input Owner own, input logic [7:0] d, input bit cd,
                            input bit e, input int lat);
    exp_t x;
    x.own = own; x.data = d; x.chk_data = cd; x.err = e;
    x.t0 = cyc; x.lat = lat; x.id = next_id;
    next_id++;
    sb.push_back(x);
  endtask

  // ---------------- monitor: all comparisons ----------------
  int   n_vec = 0;
  int   n_bad = 0;
  int   seen_expired = 0;
  int   cs_low = 0;
  bit   final_done = 1'b0;
  exp_t e;
  Owner act_own;
  logic [7:0] act_data;
  int   act_lat;
  logic [58:0] rst_vec;

  always @(negedge clk) begin
    if (chk_rst) begin
      n_vec++;
      rst_vec = {bus.o_cs, bus.o_write, bus.o_address, bus.o_dataToWrite, bus.o_vicAck,
                 bus.o_cpuAck, bus.o_vicData, bus.o_cpuData, bus.o_error};
      if (rst_vec !== {1'b1, 1'b0, 24'h0, 8'h0, 1'b0, 1'b0, 8'h0, 8'h0, 1'b0}) begin
        n_bad++;
        $display("FAIL reset_state: got %h, expected %h", rst_vec,
                 {1'b1, 1'b0, 24'h0, 8'h0, 1'b0, 1'b0, 8'h0, 8'h0, 1'b0});
      end
    end
    if (force_busy) begin
      n_vec++;
      if (bus.o_cs !== 1'b1) begin
        n_bad++;
        $display("FAIL cs_while_busy: got cs=%b, expected 1", bus.o_cs);
      end
    end
    if (bus.o_cs === 1'b0) begin
      cs_low++;
    end else if (cs_low != 0) begin
      n_vec++;
      if (cs_low != 1) begin
        n_bad++;
        $display("FAIL cs_width: got %0d cycles low, expected 1", cs_low);
      end
      cs_low = 0;
    end
    if (bus.o_vicAck === 1'b1 || bus.o_cpuAck === 1'b1) begin
      n_vec++;
      if (bus.o_vicAck === 1'b1 && bus.o_cpuAck === 1'b1) begin
        n_bad++;
        $display("FAIL dual_ack: got both acks high, expected one");
      end else if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_ack: got vic=%b cpu=%b, expected no ack", bus.o_vicAck, bus.o_cpuAck);
      end else begin
        e = sb.pop_front();
        act_own  = (bus.o_cpuAck === 1'b1) ? ownCpu : ownVic;
        act_data = (act_own == ownCpu) ? bus.o_cpuData : bus.o_vicData;
        act_lat  = cyc - e.t0;
        if (act_own != e.own || (e.chk_data && act_data !== e.data) ||
            bus.o_error !== e.err || (e.lat >= 0 && act_lat != e.lat)) begin
          n_bad++;
          $display("FAIL ack vec%0d: got own=%0d data=%02h err=%b lat=%0d, expected own=%0d data=%02h err=%b lat=%0d",
                   e.id, act_own, act_data, bus.o_error, act_lat, e.own, e.data, e.err, e.lat);
        end else begin
          $display("ack vec%0d own=%0d data=%02h err=%b lat=%0d ok", e.id, act_own, act_data,
                   bus.o_error, act_lat);
        end
      end
    end
    if (n_expired != seen_expired) begin
      n_vec++;
      n_bad++;
      $display("FAIL ack_wait: got no ack within budget, expected ack (%0d pending)", sb.size());
      seen_expired = n_expired;
    end
    if (final_chk && !final_done) begin
      n_vec++;
      if (sb.size() != 0) begin
        n_bad++;
        $display("FAIL leftover: got %0d unacked requests, expected 0", sb.size());
      end
      final_done = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  // Wait for n acks; drop a requester's req on the cycle after its ack
  // (VIC keeps requesting until it has seen vic_hold acks).
  task automatic serve(input int n_acks, input int vic_hold, input int budget);
    int got = 0;
    int vgot = 0;
    int left = budget;
    while (got < n_acks && left > 0) begin
      @(negedge clk);
      left--;
      if (bus.o_vicAck === 1'b1) begin
        got++;
        vgot++;
        @(posedge clk); #1;
        if (vgot >= vic_hold) bus.i_vicReq = 1'b0;
      end else if (bus.o_cpuAck === 1'b1) begin
        got++;
        @(posedge clk); #1;
        bus.i_cpuReq = 1'b0;
      end
    end
    if (got < n_acks) begin
      n_expired++;
      bus.i_vicReq = 1'b0;
      bus.i_cpuReq = 1'b0;
    end
  endtask

  task automatic cpu_req(input logic we, input logic [23:0] a, input logic [7:0] d);
    bus.i_cpuReq = 1'b1; bus.i_cpuWe = we; bus.i_cpuAddr = a; bus.i_cpuDataW = d;
  endtask

  task automatic vic_req(input logic [23:0] a);
    bus.i_vicReq = 1'b1; bus.i_vicAddr = a;
  endtask

  initial begin
    bus.i_vicReq = 1'b0; bus.i_vicAddr = 24'h0;
    bus.i_cpuReq = 1'b0; bus.i_cpuWe = 1'b0; bus.i_cpuAddr = 24'h0; bus.i_cpuDataW = 8'h0;

    // reset state
    repeat (3) @(posedge clk);
    #1 chk_rst = 1'b1;
    @(posedge clk); #1 chk_rst = 1'b0; reset = 1'b0;

    // 1: CPU write then read back; latency 3 + 6 busy cycles
    @(posedge clk); #1;
    cpu_req(1'b1, 24'h000001, 8'hAA);
    expect_ack(ownCpu, 8'h00, 1'b0, 1'b0, 9);
    serve(1, 1, 50);
    @(posedge clk); #1;
    cpu_req(1'b0, 24'h000001, 8'h00);
    expect_ack(ownCpu, 8'hAA, 1'b1, 1'b0, 9);
    serve(1, 1, 50);

    // 2: simultaneous requests: VIC first, CPU after one IDLE gap
    @(posedge clk); #1;
    vic_req(24'h000010);
    cpu_req(1'b0, 24'h000020, 8'h00);
    expect_ack(ownVic, 8'h4A, 1'b1, 1'b0, 9);
    expect_ack(ownCpu, 8'h7A, 1'b1, 1'b0, 19);
    serve(2, 1, 100);

    // 3: VIC held, CPU pending: CPU wins after exactly 4 VIC acks
    @(posedge clk); #1;
    vic_req(24'h000011);
    cpu_req(1'b0, 24'h000030, 8'h00);
    expect_ack(ownVic, 8'h4B, 1'b1, 1'b0, 9);
    expect_ack(ownVic, 8'h4B, 1'b1, 1'b0, 19);
    expect_ack(ownVic, 8'h4B, 1'b1, 1'b0, 29);
    expect_ack(ownVic, 8'h4B, 1'b1, 1'b0, 39);
    expect_ack(ownCpu, 8'h6A, 1'b1, 1'b0, 49);
    serve(5, 4, 200);

    // 6: busy held in IDLE: no cs until it drops, then normal sequence
    @(posedge clk); #1;
    force_busy = 1'b1;
    vic_req(24'h000012);
    expect_ack(ownVic, 8'h48, 1'b1, 1'b0, 17);
    repeat (8) @(posedge clk);
    #1 force_busy = 1'b0;
    serve(1, 1, 50);

    // 4: memCtrl never signals data: ISSUE, WAITB, 1023 DONE cycles, RESP
    @(posedge clk); #1;
    no_ready = 1'b1;
    cpu_req(1'b0, 24'h000040, 8'h00);
    expect_ack(ownCpu, 8'hFF, 1'b1, 1'b1, 1026);
    serve(1, 1, 1200);
    no_ready = 1'b0;
    // error stays set on the following normal transaction
    @(posedge clk); #1;
    vic_req(24'h000013);
    expect_ack(ownVic, 8'h49, 1'b1, 1'b1, 9);
    serve(1, 1, 50);

    // 5: reset while in DONE: everything back to reset values, no ack
    @(posedge clk); #1;
    cpu_req(1'b1, 24'h000002, 8'h55);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    bus.i_cpuReq = 1'b0;
    sb.delete();
    @(posedge clk); #1 chk_rst = 1'b1;
    @(posedge clk); #1 chk_rst = 1'b0; reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cpu_req(1'b0, 24'h000001, 8'h00);
    expect_ack(ownCpu, 8'hAA, 1'b1, 1'b0, 9);
    serve(1, 1, 50);

    @(posedge clk); #1 final_chk = 1'b1;
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
